// File: rtl/mem_requester_pkg.sv
// Shared types and constants for the multi-channel memory requester.
// Channel FSM encoding and width helpers used by the top level and the channel block.
package mem_requester_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READ_WAIT   = 3'd1,
    WRITE_WAIT  = 3'd2,
    READ_RELAY  = 3'd3,
    WRITE_RELAY = 3'd4
  } chan_state_t;

  // Upper bound on channel count and the width needed to hold such a count.
  localparam int MAX_CHANNELS = 16;
  localparam int CHAN_CNT_W   = $clog2(MAX_CHANNELS + 1);

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_req_channel.sv
// One memory channel: claim/wait/relay FSM plus its address, data and pointer registers.
// Arbitration and the claim table live in the top level; this block only follows grants.
module mem_req_channel
  import mem_requester_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 8,
  parameter int MEM_DATA_BITS = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int IDX_W         = idx_w(NUM_CONSUMERS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     grant_read,
  input  logic                     grant_write,
  input  logic [IDX_W-1:0]         grant_idx,
  input  logic [MEM_ADDR_BITS-1:0] grant_read_address,
  input  logic [MEM_ADDR_BITS-1:0] grant_write_address,
  input  logic [MEM_DATA_BITS-1:0] grant_write_data,
  input  logic                     owner_read_valid,
  input  logic                     owner_write_valid,
  output chan_state_t              state,
  output logic [IDX_W-1:0]         owner,
  output logic [IDX_W-1:0]         ptr,
  output logic                     release_claim,
  output logic                     mem_read_valid,
  output logic [MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [MEM_DATA_BITS-1:0] mem_read_data,
  output logic                     mem_write_valid,
  output logic [MEM_ADDR_BITS-1:0] mem_write_address,
  output logic [MEM_DATA_BITS-1:0] mem_write_data,
  input  logic                     mem_write_ready,
  output logic [MEM_DATA_BITS-1:0] read_data
);

  chan_state_t next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state      = state;
    release_claim   = 1'b0;
    mem_read_valid  = 1'b0;
    mem_write_valid = 1'b0;
    case (state)
      IDLE: begin
        if (grant_read) begin
          next_state = READ_WAIT;
        end else if (grant_write) begin
          next_state = WRITE_WAIT;
        end
      end
      READ_WAIT: begin
        mem_read_valid = 1'b1;
        if (mem_read_ready) begin
          next_state = READ_RELAY;
        end
      end
      WRITE_WAIT: begin
        mem_write_valid = 1'b1;
        if (mem_write_ready) begin
          next_state = WRITE_RELAY;
        end
      end
      // Relay lasts until the owner drops its request; a request already
      // dropped during the wait makes this a single-cycle pulse.
      READ_RELAY: begin
        if (!owner_read_valid) begin
          next_state    = IDLE;
          release_claim = 1'b1;
        end
      end
      WRITE_RELAY: begin
        if (!owner_write_valid) begin
          next_state    = IDLE;
          release_claim = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner             <= '0;
      ptr               <= '0;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      read_data         <= '0;
    end else begin
      if (state == IDLE && grant_read) begin
        owner            <= grant_idx;
        mem_read_address <= grant_read_address;
      end else if (state == IDLE && grant_write) begin
        owner             <= grant_idx;
        mem_write_address <= grant_write_address;
        mem_write_data    <= grant_write_data;
      end
      if (state == READ_WAIT && mem_read_ready) begin
        read_data <= mem_read_data;
      end
      if (release_claim) begin
        ptr <= (owner == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_requester.sv
// Multi-channel memory requester: arbitrates consumer read/write requests onto
// NUM_CHANNELS memory channels, with a claim table so no consumer is served twice.
module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 8,
  parameter int MEM_DATA_BITS = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_CONSUMERS-1:0]                     consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][MEM_ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                     consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][MEM_DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                     consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][MEM_ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][MEM_DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                     consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                      mem_read_valid,
  output logic [NUM_CHANNELS-1:0][MEM_ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                      mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][MEM_DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                      mem_write_valid,
  output logic [NUM_CHANNELS-1:0][MEM_ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][MEM_DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                      mem_write_ready
);

  localparam int IDX_W = idx_w(NUM_CONSUMERS);
  localparam bit WR_EN = (WRITE_ENABLE != 0);

  chan_state_t              ch_state  [NUM_CHANNELS];
  logic [IDX_W-1:0]         ch_owner  [NUM_CHANNELS];
  logic [IDX_W-1:0]         ch_ptr    [NUM_CHANNELS];
  logic [IDX_W-1:0]         grant_idx [NUM_CHANNELS];
  logic [MEM_DATA_BITS-1:0] ch_rdata  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0]                    grant_read;
  logic [NUM_CHANNELS-1:0]                    grant_write;
  logic [NUM_CHANNELS-1:0]                    ch_release;
  logic [NUM_CHANNELS-1:0]                    owner_rv;
  logic [NUM_CHANNELS-1:0]                    owner_wv;
  logic [NUM_CHANNELS-1:0]                    ch_wvalid;
  logic [NUM_CHANNELS-1:0][MEM_ADDR_BITS-1:0] ch_waddr;
  logic [NUM_CHANNELS-1:0][MEM_DATA_BITS-1:0] ch_wdata;

  logic [NUM_CONSUMERS-1:0] claimed;
  logic [NUM_CONSUMERS-1:0] claimed_next;
  logic [NUM_CONSUMERS-1:0] write_req;
  logic [NUM_CONSUMERS-1:0] taken;
  logic                     found;
  int                       scan;
  logic [IDX_W-1:0]         cand;

  assign write_req = WR_EN ? consumer_write_valid : '0;

  // Channels arbitrate in index order; each skips consumers already claimed
  // or picked by a lower channel this cycle, scanning from its own pointer.
  always_comb begin
    taken       = '0;
    found       = 1'b0;
    scan        = 0;
    cand        = '0;
    grant_read  = '0;
    grant_write = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_idx[c] = '0;
      found        = 1'b0;
      if (ch_state[c] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          scan = int'(ch_ptr[c]) + k;
          if (scan >= NUM_CONSUMERS) begin
            scan = scan - NUM_CONSUMERS;
          end
          cand = IDX_W'(scan);
          if (!found && !claimed[cand] && !taken[cand] &&
              (consumer_read_valid[cand] || write_req[cand])) begin
            found        = 1'b1;
            taken[cand]  = 1'b1;
            grant_idx[c] = cand;
            if (consumer_read_valid[cand]) begin
              grant_read[c] = 1'b1;
            end else begin
              grant_write[c] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    claimed_next = claimed;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_release[c]) begin
        claimed_next[ch_owner[c]] = 1'b0;
      end
      if (grant_read[c] || grant_write[c]) begin
        claimed_next[grant_idx[c]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      claimed <= '0;
    end else begin
      claimed <= claimed_next;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    assign owner_rv[g] = consumer_read_valid[ch_owner[g]];
    assign owner_wv[g] = write_req[ch_owner[g]];

    mem_req_channel #(
      .MEM_ADDR_BITS (MEM_ADDR_BITS),
      .MEM_DATA_BITS (MEM_DATA_BITS),
      .NUM_CONSUMERS (NUM_CONSUMERS),
      .IDX_W         (IDX_W)
    ) u_chan (
      .clk                 (clk),
      .rst_n               (rst_n),
      .grant_read          (grant_read[g]),
      .grant_write         (grant_write[g]),
      .grant_idx           (grant_idx[g]),
      .grant_read_address  (consumer_read_address[grant_idx[g]]),
      .grant_write_address (consumer_write_address[grant_idx[g]]),
      .grant_write_data    (consumer_write_data[grant_idx[g]]),
      .owner_read_valid    (owner_rv[g]),
      .owner_write_valid   (owner_wv[g]),
      .state               (ch_state[g]),
      .owner               (ch_owner[g]),
      .ptr                 (ch_ptr[g]),
      .release_claim       (ch_release[g]),
      .mem_read_valid      (mem_read_valid[g]),
      .mem_read_address    (mem_read_address[g]),
      .mem_read_ready      (mem_read_ready[g]),
      .mem_read_data       (mem_read_data[g]),
      .mem_write_valid     (ch_wvalid[g]),
      .mem_write_address   (ch_waddr[g]),
      .mem_write_data      (ch_wdata[g]),
      .mem_write_ready     (mem_write_ready[g]),
      .read_data           (ch_rdata[g])
    );

    // Write ports are tied off entirely when writes are disabled.
    assign mem_write_valid[g]   = WR_EN && ch_wvalid[g];
    assign mem_write_address[g] = WR_EN ? ch_waddr[g] : '0;
    assign mem_write_data[g]    = WR_EN ? ch_wdata[g] : '0;
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    consumer_read_data   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_state[c] == READ_RELAY) begin
        consumer_read_ready[ch_owner[c]] = 1'b1;
        consumer_read_data[ch_owner[c]]  = ch_rdata[c];
      end
      if (WR_EN && ch_state[c] == WRITE_RELAY) begin
        consumer_write_ready[ch_owner[c]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester: table of single transactions plus
// hand-written contention, backpressure, reset and ordering sequences.
module tb_mem_requester;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]       crv, cwv, crr, cwr;
  logic [3:0][7:0]  craddr, cwaddr;
  logic [3:0][15:0] cwdata, crd;
  logic [1:0]       mrv, mwv, mrr, mwr;
  logic [1:0][7:0]  mra, mwa;
  logic [1:0][15:0] mrd, mwd;

  mem_requester dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .consumer_read_valid    (crv),
    .consumer_read_address  (craddr),
    .consumer_read_ready    (crr),
    .consumer_read_data     (crd),
    .consumer_write_valid   (cwv),
    .consumer_write_address (cwaddr),
    .consumer_write_data    (cwdata),
    .consumer_write_ready   (cwr),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr)
  );

  logic [15:0] mem_model [256];
  int          lat;
  int          rcnt [2];
  int          wcnt [2];
  logic [7:0]  last_raddr, last_waddr;
  logic [15:0] last_wdata;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit          wr;
    int          cons;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] exp_data;
    int          exp_cyc;
  } vec_t;
  vec_t vecs [6];

  // Memory responder: ready rises once valid has been seen for lat+1 negedges.
  initial begin
    mrr = '0; mwr = '0; mrd = '0;
    last_raddr = '0; last_waddr = '0; last_wdata = '0;
    for (int c = 0; c < 2; c++) begin rcnt[c] = 0; wcnt[c] = 0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (mrv[c] && !mrr[c]) begin
          rcnt[c]++;
          if (rcnt[c] >= lat + 1) begin
            mrr[c] = 1'b1;
            mrd[c] = mem_model[mra[c]];
            last_raddr = mra[c];
          end
        end else begin
          mrr[c] = 1'b0;
          rcnt[c] = 0;
        end
        if (mwv[c] && !mwr[c]) begin
          wcnt[c]++;
          if (wcnt[c] >= lat + 1) begin
            mwr[c] = 1'b1;
            mem_model[mwa[c]] = mwd[c];
            last_waddr = mwa[c];
            last_wdata = mwd[c];
          end
        end else begin
          mwr[c] = 1'b0;
          wcnt[c] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input bit wr, input int c, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!(wr ? cwr[c] : crr[c]) && cyc < budget);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc, hold, bc, pulses;
    int          rise_at [4];
    int          nrise [4];
    logic [15:0] got [4];
    logic [3:0]  prev;

    for (int i = 0; i < 256; i++) mem_model[i] = 16'(i * 257) ^ 16'h5A5A;
    mem_model[8'h12] = 16'hBEEF;
    mem_model[8'hFF] = 16'hA5A5;
    mem_model[8'h33] = 16'hC0DE;
    for (int i = 0; i < 4; i++) mem_model[8'(8'h20 + i)] = 16'(16'h1000 + i);

    vecs[0] = '{1'b0, 0, 8'h12, 16'h0000, 1, 16'hBEEF, 3};
    vecs[1] = '{1'b1, 2, 8'h40, 16'h1234, 2, 16'h1234, 4};
    vecs[2] = '{1'b0, 3, 8'h40, 16'h0000, 1, 16'h1234, 3};
    vecs[3] = '{1'b0, 1, 8'hFF, 16'h0000, 3, 16'hA5A5, 5};
    vecs[4] = '{1'b1, 3, 8'h00, 16'hFFFF, 1, 16'hFFFF, 3};
    vecs[5] = '{1'b0, 0, 8'h00, 16'h0000, 1, 16'hFFFF, 3};

    rst_n = 1'b0; lat = 1;
    crv = '0; cwv = '0; craddr = '0; cwaddr = '0; cwdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", 32'({mrv, mwv}), 32'h0);
    chk("rst_mem_addr", 32'({mra, mwa}), 32'h0);
    chk("rst_mem_wdata", 32'(mwd), 32'h0);
    chk("rst_cons_ready", 32'({crr, cwr}), 32'h0);
    chk("rst_read_data", 32'(|crd), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: four readers, two channels, pointers fresh from reset.
    for (int i = 0; i < 4; i++) begin
      craddr[i] = 8'(8'h20 + i); rise_at[i] = -1; nrise[i] = 0; got[i] = '0;
    end
    prev = '0;
    crv = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (crr[i] && !prev[i]) begin
          nrise[i]++;
          if (rise_at[i] < 0) rise_at[i] = k;
          got[i] = crd[i];
        end
        if (crr[i]) crv[i] = 1'b0;
      end
      prev = crr;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_rise_c%0d", i), 32'(rise_at[i]), (i < 2) ? 32'd2 : 32'd6);
      chk($sformatf("cont_count_c%0d", i), 32'(nrise[i]), 32'd1);
      chk($sformatf("cont_data_c%0d", i), 32'(got[i]), 32'(16'h1000 + i));
    end
    repeat (2) @(negedge clk);

    // Table of single transactions.
    for (int i = 0; i < 6; i++) begin
      lat = vecs[i].lat;
      @(negedge clk);
      if (vecs[i].wr) begin
        cwaddr[vecs[i].cons] = vecs[i].addr;
        cwdata[vecs[i].cons] = vecs[i].wdata;
        cwv[vecs[i].cons] = 1'b1;
      end else begin
        craddr[vecs[i].cons] = vecs[i].addr;
        crv[vecs[i].cons] = 1'b1;
      end
      wait_ready(vecs[i].wr, vecs[i].cons, 40, cyc);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_mem_waddr", i), 32'(last_waddr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_mem_wdata", i), 32'(last_wdata), 32'(vecs[i].exp_data));
        @(posedge clk); #1;
        chk($sformatf("v%0d_relay_hold", i), 32'(cwr[vecs[i].cons]), 32'd1);
        @(negedge clk);
        cwv[vecs[i].cons] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ready_drop", i), 32'(cwr[vecs[i].cons]), 32'd0);
      end else begin
        chk($sformatf("v%0d_mem_raddr", i), 32'(last_raddr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_read_data", i), 32'(crd[vecs[i].cons]), 32'(vecs[i].exp_data));
        @(posedge clk); #1;
        chk($sformatf("v%0d_relay_hold", i), 32'({crr[vecs[i].cons], crd[vecs[i].cons]}),
            32'({1'b1, vecs[i].exp_data}));
        @(negedge clk);
        crv[vecs[i].cons] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ready_drop", i), 32'(crr[vecs[i].cons]), 32'd0);
      end
      repeat (2) @(negedge clk);
    end

    // Backpressure: memory withholds ready for 10 cycles.
    lat = 10;
    @(negedge clk);
    craddr[1] = 8'h33; crv[1] = 1'b1;
    @(negedge clk);
    chk("bp_one_channel", 32'(mrv == 2'b01 || mrv == 2'b10), 32'd1);
    bc = mrv[0] ? 0 : 1;
    hold = 0;
    for (int k = 0; k < 10; k++) begin
      if (mrv[bc] === 1'b1 && mra[bc] === 8'h33) hold++;
      @(negedge clk);
    end
    chk("bp_hold_cycles", 32'(hold), 32'd10);
    wait_ready(1'b0, 1, 10, cyc);
    chk("bp_data", 32'({crr[1], crd[1]}), 32'({1'b1, 16'hC0DE}));
    @(negedge clk); crv[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Read and write together from consumer 1: read first, write after release.
    lat = 1;
    craddr[1] = 8'h12; cwaddr[1] = 8'h77; cwdata[1] = 16'h5678;
    crv[1] = 1'b1; cwv[1] = 1'b1;
    wait_ready(1'b0, 1, 20, cyc);
    chk("rw_read_latency", 32'(cyc), 32'd3);
    chk("rw_read_data", 32'(crd[1]), 32'hBEEF);
    chk("rw_write_held", 32'({cwr[1], |mwv}), 32'd0);
    @(negedge clk); crv[1] = 1'b0;
    wait_ready(1'b1, 1, 20, cyc);
    chk("rw_write_latency", 32'(cyc), 32'd4);
    chk("rw_write_mem", 32'({last_waddr, last_wdata}), 32'({8'h77, 16'h5678}));
    @(negedge clk); cwv[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Consumer drops valid during the wait: transaction completes, 1-cycle relay.
    lat = 3;
    craddr[0] = 8'h20; crv[0] = 1'b1;
    @(negedge clk); crv[0] = 1'b0;
    pulses = 0; got[0] = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (crr[0]) begin pulses++; got[0] = crd[0]; end
    end
    chk("drop_pulse_cycles", 32'(pulses), 32'd1);
    chk("drop_data", 32'(got[0]), 32'h1000);
    @(negedge clk);

    // Reset during READ_WAIT, then a normal request afterwards.
    lat = 5;
    craddr[2] = 8'h12; crv[2] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstw_in_wait", 32'(|mrv), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_valids", 32'({mrv, mwv, crr, cwr}), 32'h0);
    chk("rstw_addr", 32'({mra, mwa}), 32'h0);
    chk("rstw_read_data", 32'(|crd), 32'h0);
    crv[2] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_no_completion", 32'({crr, cwr}), 32'h0);
    lat = 1;
    crv[2] = 1'b1;
    wait_ready(1'b0, 2, 20, cyc);
    chk("rstw_after_latency", 32'(cyc), 32'd3);
    chk("rstw_after_data", 32'(crd[2]), 32'hBEEF);
    @(negedge clk); crv[2] = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 The module SHALL have parameter MEM_ADDR_BITS, default 8, meaning the memory address width.
REQ-002 The module SHALL have parameter MEM_DATA_BITS, default 16, meaning the memory data width.
REQ-003 The module SHALL have parameter NUM_CONSUMERS, default 4, meaning the number of requesting units.
REQ-004 The module SHALL have parameter NUM_CHANNELS, default 2, meaning the number of memory channels; the legal range is 1 to NUM_CONSUMERS.
REQ-005 The module SHALL have parameter WRITE_ENABLE, default 1; when it is 0, all write ports are tied off and write requests are ignored.
REQ-006 clk  input  1  The single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  Asynchronous, active-low reset.
REQ-008 consumer_read_valid  input  [NUM_CONSUMERS]  Per-consumer read request, held until serviced.
REQ-009 consumer_read_address  input  [NUM_CONSUMERS][MEM_ADDR_BITS]  Read address, stable while valid.
REQ-010 consumer_read_ready  output  [NUM_CONSUMERS]  Read data available.
REQ-011 consumer_read_data  output  [NUM_CONSUMERS][MEM_DATA_BITS]  Returned read data.
REQ-012 consumer_write_valid, consumer_write_address, consumer_write_data  input  per consumer  Write request with the same rules as reads.
REQ-013 consumer_write_ready  output  [NUM_CONSUMERS]  Write completed.
REQ-014 mem_read_valid, mem_read_address  output  [NUM_CHANNELS]  Per-channel read request to memory.
REQ-015 mem_read_ready, mem_read_data  input  [NUM_CHANNELS]  Memory read acknowledge and read data.
REQ-016 mem_write_valid, mem_write_address, mem_write_data  output; mem_write_ready  input  [NUM_CHANNELS]  Per-channel write request and acknowledge.

Function
REQ-017 Each channel SHALL run its own finite-state machine with the states IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY and WRITE_RELAY.
REQ-018 In IDLE, a channel SHALL claim the first unclaimed consumer that has a request, scanning from its round-robin pointer upward with wrap-around; reads win over writes for the same consumer.
REQ-019 In any one cycle, a consumer SHALL be claimed by at most one channel; the lowest-indexed idle channel wins, and higher channels continue the scan past it.
REQ-020 When a channel claims a consumer, it SHALL register the address (and, for writes, the data), drive mem_*_valid=1 on the next cycle, and enter READ_WAIT or WRITE_WAIT.
REQ-021 In READ_WAIT or WRITE_WAIT, the channel SHALL hold mem_*_valid and the address/data stable until it samples mem_*_ready=1.
REQ-022 When mem_*_ready=1 is sampled, the channel SHALL drop mem_*_valid, latch mem_read_data (reads only), assert consumer_*_ready, and enter the matching RELAY state.
REQ-023 In a RELAY state, consumer_*_ready and consumer_read_data SHALL stay stable until the consumer deasserts its valid.
REQ-024 When the consumer deasserts its valid, the channel SHALL clear consumer_*_ready, release the claim, advance its pointer to claimed+1 mod NUM_CONSUMERS, and return to IDLE.
REQ-025 Minimum read latency from consumer valid to consumer ready SHALL be 3 cycles when memory answers in 1 cycle.
REQ-026 A consumer dropping its valid during a WAIT state SHALL NOT abort the memory transaction; the RELAY state then completes in 1 cycle.
REQ-027 A claimed consumer SHALL NOT be re-claimed until its claim is released, even if it re-asserts valid during RELAY.
REQ-028 If memory asserts ready while the channel is not in a WAIT state, it SHALL be ignored.

Reset
REQ-029 While rst_n=0, every channel SHALL be in IDLE.
REQ-030 While rst_n=0, all claims SHALL be cleared and all pointers SHALL be 0.
REQ-031 While rst_n=0, all mem_*_valid, mem_*_address, mem_write_data, consumer_*_ready and consumer_read_data outputs SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no completion signalled.

Structure
REQ-033 The state encodings and a channel-count width constant SHALL live in the shared package.
REQ-034 There SHALL be one sub-module, mem_req_channel, holding the per-channel FSM and data registers; the claim table and the arbitration logic stay in the top level.

Verification
REQ-035 Single read: consumer 0 reads address 0x12 and memory returns 0xBEEF with a 1-cycle ready -> consumer_read_ready[0] rises 3 cycles after valid with data 0xBEEF, then falls the cycle after valid drops.
REQ-036 Write: consumer 2 writes 0x1234 to address 0x40 -> mem_write_address=0x40 and mem_write_data=0x1234 held until mem_write_ready, then consumer_write_ready[2]=1.
REQ-037 Contention: all four consumers read at once with NUM_CHANNELS=2 -> channels serve 0 and 1 first, then 2 and 3, with no consumer served twice.
REQ-038 Backpressure: mem_read_ready is withheld for 10 cycles -> mem_read_valid and the address stay constant for all 10 cycles.
REQ-039 Reset during READ_WAIT -> all outputs are 0 in the same cycle, and after rst_n=1 a new request is served normally.
REQ-040 Read and write together from consumer 1 -> the read is served first and the write is served after the claim is released.
